sram_ctrl: RTL and testbench

- Memory-stage controller that sequences one 32-bit load/store onto the board's 16-bit asynchronous SRAM as two half-word phases.
- Drives `ready` low for the whole access. The pipeline ORs `~ready` into its freeze, next to the hazard-detect freeze.
- Sits between the MEM stage and the SRAM pins. The DQ tristate buffer lives at the top level; this block exposes split in/out/oe.

---
 rtl/sram_ctrl_pkg.sv | 23 ++
 rtl/sram_ctrl.sv | 127 ++++++++++++
 tb/tb_sram_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the half-word SRAM sequencer.
// The helper maps a byte address to the SRAM word index (off[18:2]).
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int SRAM_AW = 18;
  localparam int SRAM_DW = 16;
  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'd1024;

  function automatic logic [SRAM_AW-2:0] word_index(input logic [31:0] address,
                                                     input logic [31:0] base);
    logic [31:0] off;
    off = address - base;
    return off[18:2];
  endfunction

endpackage

// File: rtl/sram_ctrl.sv
// Sequences one 32-bit load/store as two half-word phases on a 16-bit async SRAM.
// ready is low for the whole access so the pipeline freezes around it.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEFAULT,
  parameter int          HALF_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [31:0]        address,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [SRAM_DW-1:0] sram_dq_out,
  input  logic [SRAM_DW-1:0] sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n,
  output logic               sram_oe_n
);

  localparam logic [3:0] LAST = 4'(HALF_CYCLES - 1);

  state_t             state;
  logic [3:0]         count;
  logic               is_write;
  logic [SRAM_AW-2:0] word;
  logic [31:0]        wdata_q;
  logic               request;

  assign request = wr_en | rd_en;

  // Freeze request: low from the request cycle until the single DONE cycle.
  always_comb begin
    if (rst) begin
      ready = 1'b1;
    end else if (state == ST_DONE) begin
      ready = 1'b1;
    end else if (state == ST_IDLE) begin
      ready = ~request;
    end else begin
      ready = 1'b0;
    end
  end

  // Phase FSM; SRAM pins are registered and computed for the upcoming cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      count       <= 4'd0;
      is_write    <= 1'b0;
      word        <= '0;
      wdata_q     <= 32'd0;
      rdata       <= 32'd0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (request) begin
            state       <= ST_LO;
            count       <= 4'd0;
            is_write    <= wr_en;
            word        <= word_index(address, BASE_ADDR);
            wdata_q     <= wdata;
            sram_addr   <= {word_index(address, BASE_ADDR), 1'b0};
            sram_dq_out <= wdata[15:0];
            sram_dq_oe  <= wr_en;
            sram_we_n   <= ~wr_en;
            sram_oe_n   <= wr_en;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_LO: begin
          if (count == LAST) begin
            state       <= ST_HI;
            count       <= 4'd0;
            sram_addr   <= {word, 1'b1};
            sram_dq_out <= wdata_q[31:16];
            sram_we_n   <= ~is_write;
            if (!is_write) begin
              rdata[15:0] <= sram_dq_in;
            end
          end else begin
            count     <= count + 4'd1;
            // The final cycle of each phase releases we_n while address/data hold.
            sram_we_n <= ~(is_write && ((count + 4'd1) != LAST));
          end
        end
        ST_HI: begin
          if (count == LAST) begin
            state      <= ST_DONE;
            count      <= 4'd0;
            sram_we_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_dq_oe <= 1'b0;
            if (!is_write) begin
              rdata[31:16] <= sram_dq_in;
            end
          end else begin
            count     <= count + 4'd1;
            sram_we_n <= ~(is_write && ((count + 4'd1) != LAST));
          end
        end
        ST_DONE: begin
          // A request still held here belongs to the access just completed.
          state <= ST_IDLE;
        end
        default: begin
          state      <= ST_IDLE;
          count      <= 4'd0;
          sram_we_n  <= 1'b1;
          sram_oe_n  <= 1'b1;
          sram_dq_oe <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Randomized/directed bench for sram_ctrl with H=2 and H=4 instances,
// each attached to a behavioural async SRAM whose data is valid only late in a phase.
module tb_sram_ctrl;
  import sram_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a[2];
  logic        wr_en_a[2];
  logic        rd_en_a[2];
  logic [31:0] address_a[2];
  logic [31:0] wdata_a[2];
  logic [31:0] rdata_a[2];
  logic        ready_a[2];
  logic [17:0] sram_addr_a[2];
  logic [15:0] dq_out_a[2];
  logic [15:0] dq_in_a[2];
  logic        dq_oe_a[2];
  logic        we_n_a[2];
  logic        oe_n_a[2];

  sram_ctrl #(.BASE_ADDR(32'd1024), .HALF_CYCLES(2)) dut (
    .clk(clk), .rst(rst_a[0]), .wr_en(wr_en_a[0]), .rd_en(rd_en_a[0]),
    .address(address_a[0]), .wdata(wdata_a[0]), .rdata(rdata_a[0]), .ready(ready_a[0]),
    .sram_addr(sram_addr_a[0]), .sram_dq_out(dq_out_a[0]), .sram_dq_in(dq_in_a[0]),
    .sram_dq_oe(dq_oe_a[0]), .sram_we_n(we_n_a[0]), .sram_oe_n(oe_n_a[0]));

  sram_ctrl #(.BASE_ADDR(32'd1024), .HALF_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst_a[1]), .wr_en(wr_en_a[1]), .rd_en(rd_en_a[1]),
    .address(address_a[1]), .wdata(wdata_a[1]), .rdata(rdata_a[1]), .ready(ready_a[1]),
    .sram_addr(sram_addr_a[1]), .sram_dq_out(dq_out_a[1]), .sram_dq_in(dq_in_a[1]),
    .sram_dq_oe(dq_oe_a[1]), .sram_we_n(we_n_a[1]), .sram_oe_n(oe_n_a[1]));

  int checks = 0;
  int errors = 0;

  function automatic int hc(input int i);
    return (i == 0) ? 2 : 4;
  endfunction

  function automatic logic [15:0] pat(input int i, input int a);
    return 16'((a * 40503 + i * 7919 + 3) & 32'hFFFF);
  endfunction

  // Behavioural async SRAM: write while we_n low, read data valid once the
  // address has been stable for H-1 cycles (i.e. only on the last phase cycle).
  logic [15:0] sim_mem[2][1024];
  logic [17:0] last_addr[2];
  int          stab[2];
  logic        mem_init;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (mem_init) begin
        for (int a = 0; a < 1024; a++) sim_mem[i][a] <= pat(i, a);
      end else if (!we_n_a[i] && dq_oe_a[i]) begin
        sim_mem[i][sram_addr_a[i][9:0]] <= dq_out_a[i];
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (sram_addr_a[i] != last_addr[i]) begin
        stab[i]      <= 0;
        last_addr[i] <= sram_addr_a[i];
      end else if (stab[i] < 1000) begin
        stab[i] <= stab[i] + 1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      dq_in_a[i] = (stab[i] >= hc(i) - 1) ? sim_mem[i][sram_addr_a[i][9:0]] : 16'hBAD0;
    end
  end

  // Reference model state
  logic [15:0] ref_mem[2][1024];
  logic [31:0] ref_rdata[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One access: checks every cycle of the expected 1+2H frozen window plus DONE.
  task automatic access(input int i, input bit wr, input bit rd, input logic [31:0] addr,
                        input logic [31:0] wd, input bit hold);
    int h, lo, hi, p;
    logic [31:0] off, exp_rdata;
    bit half, e_ready, e_we, e_oe, e_dqoe;
    h   = hc(i);
    off = addr - 32'd1024;
    lo  = int'((off % 32'h80000) / 32'd4) * 2;
    hi  = lo + 1;
    exp_rdata = wr ? ref_rdata[i] : {ref_mem[i][hi % 1024], ref_mem[i][lo % 1024]};
    for (int c = 0; c <= 2 * h + 1; c++) begin
      @(negedge clk);
      if (c == 0 || hold) begin
        wr_en_a[i] = wr; rd_en_a[i] = rd; address_a[i] = addr; wdata_a[i] = wd;
      end else begin
        wr_en_a[i] = 1'b0; rd_en_a[i] = 1'b0;
        address_a[i] = $urandom; wdata_a[i] = $urandom;
      end
      #1;
      e_ready = (c == 2 * h + 1);
      chk($sformatf("i%0d a%h c%0d ready", i, addr, c), 32'(ready_a[i]), 32'(e_ready));
      if (c >= 1 && c <= 2 * h) begin
        p    = (c - 1) % h + 1;
        half = (c > h);
        chk($sformatf("i%0d a%h c%0d sram_addr", i, addr, c), 32'(sram_addr_a[i]),
            32'(half ? hi : lo));
        if (wr) begin
          e_dqoe = 1'b1; e_oe = 1'b1; e_we = (p == h);
          chk($sformatf("i%0d a%h c%0d dq_out", i, addr, c), 32'(dq_out_a[i]),
              32'(half ? wd[31:16] : wd[15:0]));
        end else begin
          e_dqoe = 1'b0; e_oe = 1'b0; e_we = 1'b1;
        end
      end else begin
        e_dqoe = 1'b0; e_oe = 1'b1; e_we = 1'b1;
      end
      chk($sformatf("i%0d a%h c%0d we_n", i, addr, c), 32'(we_n_a[i]), 32'(e_we));
      chk($sformatf("i%0d a%h c%0d oe_n", i, addr, c), 32'(oe_n_a[i]), 32'(e_oe));
      chk($sformatf("i%0d a%h c%0d dq_oe", i, addr, c), 32'(dq_oe_a[i]), 32'(e_dqoe));
      if (c == 2 * h + 1) begin
        chk($sformatf("i%0d a%h done rdata", i, addr), rdata_a[i], exp_rdata);
      end
    end
    if (!hold) begin
      wr_en_a[i] = 1'b0; rd_en_a[i] = 1'b0;
    end
    if (wr) begin
      ref_mem[i][lo % 1024] = wd[15:0];
      ref_mem[i][hi % 1024] = wd[31:16];
    end else begin
      ref_rdata[i] = exp_rdata;
    end
  endtask

  task automatic random_op(input int i);
    logic [31:0] a;
    bit w;
    a = 32'd1024 + $urandom_range(0, 4095);
    if ($urandom_range(0, 3) == 0) a = a + ($urandom << 19);
    w = $urandom_range(0, 1) == 1;
    access(i, w, !w || ($urandom_range(0, 3) == 0), a, $urandom, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst_a[i] = 1'b1; wr_en_a[i] = 1'b0; rd_en_a[i] = 1'b0;
      address_a[i] = 32'd0; wdata_a[i] = 32'd0;
      ref_rdata[i] = 32'd0;
      for (int a = 0; a < 1024; a++) ref_mem[i][a] = pat(i, a);
    end
    mem_init = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("i%0d reset ready", i), 32'(ready_a[i]), 32'd1);
      chk($sformatf("i%0d reset we_n", i), 32'(we_n_a[i]), 32'd1);
      chk($sformatf("i%0d reset oe_n", i), 32'(oe_n_a[i]), 32'd1);
      chk($sformatf("i%0d reset dq_oe", i), 32'(dq_oe_a[i]), 32'd0);
      chk($sformatf("i%0d reset rdata", i), rdata_a[i], 32'd0);
      chk($sformatf("i%0d reset sram_addr", i), 32'(sram_addr_a[i]), 32'd0);
      chk($sformatf("i%0d reset dq_out", i), 32'(dq_out_a[i]), 32'd0);
    end
    @(negedge clk);
    rst_a[0] = 1'b0; rst_a[1] = 1'b0; mem_init = 1'b0;

    // Directed store/load of 0xDEADBEEF at 1028
    access(0, 1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 1'b0);
    access(0, 1'b0, 1'b1, 32'd1028, 32'h0, 1'b0);
    chk("load 1028 value", rdata_a[0], 32'hDEADBEEF);

    // Store held through DONE, load in the very next cycle
    access(0, 1'b1, 1'b0, 32'd1100, 32'hA5A55A5A, 1'b1);
    access(0, 1'b0, 1'b1, 32'd1100, 32'h0, 1'b0);

    // Both requests set: write wins, rdata untouched
    access(0, 1'b1, 1'b1, 32'd1032, 32'h0BADF00D, 1'b0);
    access(0, 1'b0, 1'b1, 32'd1032, 32'h0, 1'b0);

    // Reset on the 3rd cycle of a store: low half already written
    @(negedge clk);
    wr_en_a[0] = 1'b1; address_a[0] = 32'd1040; wdata_a[0] = 32'h12345678;
    @(negedge clk);
    wr_en_a[0] = 1'b0;
    @(negedge clk);
    rst_a[0] = 1'b1;
    #1;
    chk("ready during rst", 32'(ready_a[0]), 32'd1);
    @(negedge clk);
    rst_a[0] = 1'b0;
    #1;
    chk("post-rst ready", 32'(ready_a[0]), 32'd1);
    chk("post-rst we_n", 32'(we_n_a[0]), 32'd1);
    chk("post-rst dq_oe", 32'(dq_oe_a[0]), 32'd0);
    chk("post-rst oe_n", 32'(oe_n_a[0]), 32'd1);
    chk("post-rst rdata", rdata_a[0], 32'd0);
    ref_mem[0][8] = 16'h5678;
    ref_rdata[0]  = 32'd0;
    access(0, 1'b0, 1'b1, 32'd1040, 32'h0, 1'b0);

    // Address wrap below BASE_ADDR and aliasing through ignored upper bits
    access(0, 1'b1, 1'b0, 32'd0, 32'hCAFEF00D, 1'b0);
    access(0, 1'b0, 1'b1, 32'd0 + (32'd5 << 19) + 32'd3, 32'h0, 1'b0);

    // H=4 instance: store then load, 9 frozen cycles, late-phase sampling
    access(1, 1'b1, 1'b0, 32'd1028, 32'h13579BDF, 1'b0);
    access(1, 1'b0, 1'b1, 32'd1028, 32'h0, 1'b0);
    chk("h4 load value", rdata_a[1], 32'h13579BDF);

    for (int n = 0; n < 40; n++) random_op(0);
    for (int n = 0; n < 12; n++) random_op(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
